// File: rtl/ysyx_22041207_div_unit_pkg.sv
// Shared divider definitions: FSM encodings, op codes with their control
// mapping, iteration counts and the word sign-extension helper.
package ysyx_22041207_div_unit_pkg;

    localparam int         DIV_XLEN   = 64;
    localparam logic [6:0] DIV_ITER_D = 7'd64;
    localparam logic [6:0] DIV_ITER_W = 7'd32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

    typedef enum logic [1:0] {
        OP_DIV  = 2'd0,
        OP_DIVU = 2'd1,
        OP_REM  = 2'd2,
        OP_REMU = 2'd3
    } div_op_e;

    typedef struct packed {
        logic is_signed;
        logic is_rem;
    } div_ctrl_t;

    function automatic div_ctrl_t div_op_ctrl(input div_op_e op);
        div_ctrl_t c;
        case (op)
            OP_DIV:  c = '{is_signed: 1'b1, is_rem: 1'b0};
            OP_DIVU: c = '{is_signed: 1'b0, is_rem: 1'b0};
            OP_REM:  c = '{is_signed: 1'b1, is_rem: 1'b1};
            OP_REMU: c = '{is_signed: 1'b0, is_rem: 1'b1};
            default: c = '{is_signed: 1'b0, is_rem: 1'b0};
        endcase
        return c;
    endfunction

    function automatic logic [63:0] sext_word(input logic [63:0] x);
        return {{32{x[31]}}, x[31:0]};
    endfunction

endpackage

// File: rtl/ysyx_22041207_div_unit_if.sv
// Request/response bundle between the execute stage (master) and the divider (slave).
interface ysyx_22041207_div_unit_if #(parameter int XLEN = 64);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            is_signed;
    logic            is_rem;
    logic            is_word;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, dividend, divisor, is_signed, is_rem, is_word, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, dividend, divisor, is_signed, is_rem, is_word, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/ysyx_22041207_div_unit_step.sv
// One radix-2 restoring step on a 2*XLEN partial remainder (upper half holds
// the running remainder, lower half the dividend bits still to consume).
module ysyx_22041207_div_step #(
    parameter int XLEN = 64
) (
    input  logic [2*XLEN-1:0] i_pr,
    input  logic [XLEN-1:0]   i_div,
    output logic [2*XLEN-1:0] o_pr,
    output logic              o_q
);
    logic [XLEN:0]   w_trial;
    logic [XLEN-1:0] w_sub;

    // Shifted remainder can reach XLEN+1 bits; a set top bit already exceeds any divisor.
    assign w_trial = i_pr[2*XLEN-1:XLEN-1];
    assign w_sub   = w_trial[XLEN-1:0] - i_div;
    assign o_q     = w_trial[XLEN] | (w_trial[XLEN-1:0] >= i_div);
    assign o_pr    = o_q ? {w_sub, i_pr[XLEN-2:0], 1'b0} : {i_pr[2*XLEN-2:0], 1'b0};
endmodule

// File: rtl/ysyx_22041207_div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU and W variants:
// operand prep and special cases at accept, one step per cycle, sign fixup.
module ysyx_22041207_div_unit
    import ysyx_22041207_div_unit_pkg::*;
#(
    parameter int XLEN = DIV_XLEN
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    ysyx_22041207_div_unit_if.slave   bus
);
    div_state_e        r_state;
    logic [6:0]        r_cnt;
    logic [2*XLEN-1:0] r_pr;
    logic [XLEN-1:0]   r_div;
    logic              r_q_neg, r_r_neg, r_is_rem, r_is_word;
    logic              r_in_ready, r_out_valid, r_busy;
    logic [XLEN-1:0]   r_result;

    logic [XLEN-1:0]   w_a_ext, w_b_ext, w_a_abs, w_b_abs, w_min, w_special;
    logic              w_a_neg, w_b_neg, w_div_zero, w_ovf;
    logic [2*XLEN-1:0] w_pre, w_step_pr;
    logic              w_step_q;
    logic [XLEN-1:0]   w_q, w_r, w_q_fix, w_r_fix, w_sel, w_fix;

    // Word operands are reduced to 64-bit values first so one datapath serves both widths.
    assign w_a_ext = bus.is_word ? (bus.is_signed ? sext_word(bus.dividend) : {32'd0, bus.dividend[31:0]})
                                 : bus.dividend;
    assign w_b_ext = bus.is_word ? (bus.is_signed ? sext_word(bus.divisor) : {32'd0, bus.divisor[31:0]})
                                 : bus.divisor;
    assign w_a_neg = bus.is_signed & w_a_ext[XLEN-1];
    assign w_b_neg = bus.is_signed & w_b_ext[XLEN-1];
    assign w_a_abs = w_a_neg ? (~w_a_ext + 64'd1) : w_a_ext;
    assign w_b_abs = w_b_neg ? (~w_b_ext + 64'd1) : w_b_ext;

    assign w_min      = bus.is_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    assign w_div_zero = (w_b_ext == 64'd0);
    assign w_ovf      = bus.is_signed & (w_a_ext == w_min) & (&w_b_ext);
    assign w_special  = w_div_zero ? (bus.is_rem ? (bus.is_word ? sext_word(bus.dividend) : bus.dividend)
                                                 : {XLEN{1'b1}})
                                   : (bus.is_rem ? 64'd0 : w_a_ext);

    // Word dividends sit in the top of the lower half so 32 steps consume exactly them.
    assign w_pre = bus.is_word ? {64'd0, w_a_abs[31:0], 32'd0} : {64'd0, w_a_abs};

    ysyx_22041207_div_step #(.XLEN(XLEN)) u_step (
        .i_pr  (r_pr),
        .i_div (r_div),
        .o_pr  (w_step_pr),
        .o_q   (w_step_q)
    );

    assign w_q     = r_pr[XLEN-1:0];
    assign w_r     = r_pr[2*XLEN-1:XLEN];
    assign w_q_fix = r_q_neg ? (~w_q + 64'd1) : w_q;
    assign w_r_fix = r_r_neg ? (~w_r + 64'd1) : w_r;
    assign w_sel   = r_is_rem ? w_r_fix : w_q_fix;
    assign w_fix   = r_is_word ? sext_word(w_sel) : w_sel;

    // Control FSM with registered handshake outputs; reset beats flush beats everything else.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 7'd0;
            r_pr        <= '0;
            r_div       <= '0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_is_rem    <= 1'b0;
            r_is_word   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_result    <= '0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 7'd0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_pr       <= w_pre;
                        r_div      <= w_b_abs;
                        r_q_neg    <= w_a_neg ^ w_b_neg;
                        r_r_neg    <= w_a_neg;
                        r_is_rem   <= bus.is_rem;
                        r_is_word  <= bus.is_word;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (w_div_zero || w_ovf) begin
                            r_result    <= w_special;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_cnt   <= bus.is_word ? DIV_ITER_W : DIV_ITER_D;
                            r_state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    r_pr  <= {w_step_pr[2*XLEN-1:1], w_step_q};
                    r_cnt <= r_cnt - 7'd1;
                    if (r_cnt == 7'd1) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_result    <= w_fix;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_ysyx_22041207_div_unit.sv
// Table-driven bench for the iterative divider with a result/latency scoreboard
// plus hand-written backpressure, flush and reset sequences.
module tb_ysyx_22041207_div_unit;
    import ysyx_22041207_div_unit_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;

    always #5 clk = ~clk;

    ysyx_22041207_div_unit_if bus();

    ysyx_22041207_div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        s;
        logic        r;
        logic        w;
        logic [63:0] exp;
        int          lat;
        int          hold;
    } vec_t;

    typedef struct {
        logic [63:0] exp;
        int          lat;
    } sb_t;

    vec_t vt[$];
    sb_t  sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input logic [63:0] a, input logic [63:0] b, input logic s,
                                input logic r, input logic w, input logic [63:0] exp,
                                input int lat, input int hold);
        vec_t v;
        v.a = a; v.b = b; v.s = s; v.r = r; v.w = w;
        v.exp = exp; v.lat = lat; v.hold = hold;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns #1 after the accept edge.
    task automatic drive(input vec_t v);
        sb_t e;
        bus.dividend  = v.a;
        bus.divisor   = v.b;
        bus.is_signed = v.s;
        bus.is_rem    = v.r;
        bus.is_word   = v.w;
        bus.in_valid  = 1'b1;
        e.exp = v.exp;
        e.lat = v.lat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.dividend = 64'hDEAD_BEEF_DEAD_BEEF;
        bus.divisor  = 64'h0123_4567_89AB_CDEF;
    endtask

    task automatic wait_result(input string name, input int hold);
        int          cyc = 0;
        bit          ctrl_ok = 1'b1;
        bit          hold_ok = 1'b1;
        logic [63:0] held;
        sb_t         e;
        do begin
            @(negedge clk);
            cyc++;
            if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) ctrl_ok = 1'b0;
        end while (bus.out_valid !== 1'b1 && cyc < 200);
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_sb: got empty scoreboard expected an entry", name);
            return;
        end
        e = sb.pop_front();
        chk({name, "_latency"}, 64'(cyc), 64'(e.lat));
        chk({name, "_result"}, bus.result, e.exp);
        chk({name, "_ctrl"}, {63'd0, ctrl_ok}, 64'd1);
        held = bus.result;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.result !== held || bus.in_ready !== 1'b0) hold_ok = 1'b0;
        end
        if (hold > 0) chk({name, "_hold"}, {63'd0, hold_ok}, 64'd1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({name, "_release"}, {61'd0, bus.out_valid, bus.in_ready, bus.busy}, 64'b010);
    endtask

    task automatic no_output(input string name, input int cycles);
        bit quiet = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) quiet = 1'b0;
        end
        chk({name, "_quiet"}, {63'd0, quiet}, 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.dividend  = 64'd0;
        bus.divisor   = 64'd0;
        bus.is_signed = 1'b0;
        bus.is_rem    = 1'b0;
        bus.is_word   = 1'b0;
        bus.out_ready = 1'b0;

        //          dividend                 divisor                  s     r     w     expected                 lat hold
        vt.push_back(mk(64'd100,              64'd7,                   1'b0, 1'b0, 1'b0, 64'd14,                  66, 5));
        vt.push_back(mk(64'd100,              64'd7,                   1'b0, 1'b1, 1'b0, 64'd2,                   66, 0));
        vt.push_back(mk(64'hFFFFFFFFFFFFFFF9, 64'd2,                   1'b1, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFD,    66, 0));
        vt.push_back(mk(64'hFFFFFFFFFFFFFFF9, 64'd2,                   1'b1, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFF,    66, 0));
        vt.push_back(mk(64'd7,                64'hFFFFFFFFFFFFFFFE,    1'b1, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFD,    66, 0));
        vt.push_back(mk(64'd7,                64'hFFFFFFFFFFFFFFFE,    1'b1, 1'b1, 1'b0, 64'd1,                   66, 0));
        vt.push_back(mk(64'hFFFFFFFFFFFFFF9C, 64'hFFFFFFFFFFFFFFF9,    1'b1, 1'b0, 1'b0, 64'd14,                  66, 0));
        vt.push_back(mk(64'hFFFFFFFFFFFFFFFF, 64'd3,                   1'b0, 1'b0, 1'b0, 64'h5555555555555555,    66, 0));
        vt.push_back(mk(64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF,    1'b0, 1'b0, 1'b0, 64'd0,                   66, 0));
        vt.push_back(mk(64'd5,                64'd0,                   1'b0, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFF,    1,  0));
        vt.push_back(mk(64'd5,                64'd0,                   1'b0, 1'b1, 1'b0, 64'd5,                   1,  3));
        vt.push_back(mk(64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF,    1'b1, 1'b0, 1'b0, 64'h8000000000000000,    1,  0));
        vt.push_back(mk(64'h8000000000000000, 64'hFFFFFFFFFFFFFFFF,    1'b1, 1'b1, 1'b0, 64'd0,                   1,  0));
        vt.push_back(mk(64'h12345678FFFFFFF9, 64'd2,                   1'b1, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFD,    34, 2));
        vt.push_back(mk(64'h00000000FFFFFFFE, 64'd1,                   1'b0, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFE,    34, 0));
        vt.push_back(mk(64'h00000000FFFFFFF9, 64'hABCD000000000002,    1'b1, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFF,    34, 0));
        vt.push_back(mk(64'h00000000FFFFFFFF, 64'd16,                  1'b0, 1'b1, 1'b1, 64'd15,                  34, 0));
        vt.push_back(mk(64'h0000000080000005, 64'hFFFFFFFF00000000,    1'b0, 1'b1, 1'b1, 64'hFFFFFFFF80000005,    1,  0));
        vt.push_back(mk(64'h0000000080000000, 64'h00000000FFFFFFFF,    1'b1, 1'b0, 1'b1, 64'hFFFFFFFF80000000,    1,  0));

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset_ctrl", {61'd0, bus.out_valid, bus.in_ready, bus.busy}, 64'b010);
        chk("reset_result", bus.result, 64'd0);

        @(negedge clk);
        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i]);
            wait_result($sformatf("vec%0d", i), vt[i].hold);
        end

        // Kill an operation partway through CALC with flush, then run a fresh one.
        drive(vt[0]);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        sb.delete();
        chk("flush_ctrl", {61'd0, bus.out_valid, bus.in_ready, bus.busy}, 64'b010);
        no_output("flush", 80);
        drive(vt[7]);
        wait_result("after_flush", 0);

        // Same kill through synchronous reset; result must return to zero.
        drive(vt[1]);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.delete();
        chk("rst_ctrl", {61'd0, bus.out_valid, bus.in_ready, bus.busy}, 64'b010);
        chk("rst_result", bus.result, 64'd0);
        no_output("rst", 80);
        drive(vt[13]);
        wait_result("after_rst", 0);

        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/ysyx_22041207_div_unit.md
Name: ysyx_22041207_div_unit

Overview:
Multi-cycle iterative integer divider. It is the responder end of a valid/ready operation-request interface: the execute stage issues DIV/DIVU/REM/REMU and the W variants here instead of evaluating them in one combinational cycle. The block accepts one request, runs a radix-2 restoring loop and returns one 64-bit result through an output valid/ready handshake. It sits beside the ALU in the execute stage.

Parameters:
XLEN, 64, operand/result width; must be 64.

Ports:
clk  in  1  core clock, all state updates on posedge
rst_n  in  1  synchronous reset, active-low
flush  in  1  synchronous kill of any in-flight operation
in_valid  in  1  request valid
in_ready  out  1  block can accept a request (high only in IDLE)
dividend  in  64  rs1 value
divisor  in  64  rs2 value
is_signed  in  1  1 = DIV/REM, 0 = DIVU/REMU
is_rem  in  1  1 = return remainder, 0 = return quotient
is_word  in  1  1 = W variant; uses low 32 bits only
out_valid  out  1  result valid
out_ready  in  1  consumer takes result
result  out  64  quotient or remainder
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low at posedge): state=IDLE, out_valid=0, result=0, busy=0, counter=0. in_ready=1 in the first cycle after reset. Reset mid-operation discards the operation and produces no output.
- States: IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1. A request is accepted on a posedge with in_valid & in_ready & !flush. Operands and op bits are latched at that edge.
- Accept, normal case -> CALC with counter=N (N=64, or 32 if is_word).
- Accept, special case -> DONE directly, with result already loaded:
  - divisor==0: quotient = all ones (width-extended); remainder = dividend.
  - Signed overflow (dividend = most-negative value, divisor = -1): quotient = dividend; remainder = 0.
  - Special-case latency: out_valid is high in the cycle after the accept cycle.
- Operand prep at accept:
  - Word mode: take bits [31:0]. Sign-extend if is_signed, else zero-extend.
  - Signed mode: take absolute values. Record quotient sign = sign(dividend) XOR sign(divisor). Record remainder sign = sign(dividend).
- CALC: one restoring step per cycle, on a 2N-bit partial remainder:
  - shift left 1;
  - trial-subtract the divisor;
  - if the trial is non-negative, keep the difference and set quotient bit to 1;
  - counter decrements.
  - When counter reaches 1 at an edge, go to FIX.
- FIX (1 cycle):
  - Apply recorded signs (two's-complement negate).
  - Select quotient or remainder per is_rem.
  - Word mode: sign-extend bit 31 of the 32-bit result to 64 bits. This applies to signed and unsigned word ops.
  - Register result, go to DONE.
- Normal latency: first out_valid cycle is N+2 cycles after the accept cycle, i.e. 66 (64-bit) or 34 (word).
- DONE: out_valid=1; result is held stable while out_ready is low. On a posedge with out_ready=1, go to IDLE and deassert out_valid. No new request is accepted in the same cycle (in_ready=0 in DONE).
- flush: at the next posedge, from any state, go to IDLE with out_valid=0. flush takes priority over in_valid and out_ready in the same cycle. rst_n takes priority over flush.
- result keeps its last value while not valid. Consumers must qualify it with out_valid.

Decomposition:
- Shared define file (alongside the ALU opcode defines): state encodings, DIV/DIVU/REM/REMU op codes and the mapping to {is_signed, is_rem}, iteration counts 64/32.
- Sub-module ysyx_22041207_div_step: combinational single restoring step.
  - Inputs: partial remainder, divisor.
  - Outputs: next partial remainder, quotient bit.
- The top module holds the FSM, counter, sign fixup and handshakes.

Test Plan:
- DIVU 100 / 7, is_rem=0 -> result=14, out_valid exactly 66 cycles after accept. in_ready=0 and busy=1 throughout. REMU 100 / 7 -> result=2.
- DIV -7 / 2 -> 0xFFFFFFFFFFFFFFFD. REM -7 % 2 -> 0xFFFFFFFFFFFFFFFF. DIV 7 / -2 -> 0xFFFFFFFFFFFFFFFD.
- DIVU 5 / 0 -> 0xFFFFFFFFFFFFFFFF. REMU 5 / 0 -> 5. Both with out_valid 1 cycle after accept.
- DIV 0x8000000000000000 / 0xFFFFFFFFFFFFFFFF -> 0x8000000000000000. REM of the same operands -> 0. Latency 1.
- DIVW dividend 0x12345678FFFFFFF9 / 2 -> 0xFFFFFFFFFFFFFFFD with latency 34. DIVUW 0x00000000FFFFFFFE / 1 -> 0xFFFFFFFFFFFFFFFE.
- Backpressure and kill:
  - out_ready held low 5 cycles in DONE -> result and out_valid stable; IDLE one cycle after out_ready rises.
  - flush at cycle 10 of CALC -> no out_valid; in_ready=1 next cycle; a new request then completes correctly.
  - rst_n low mid-CALC -> same outcome.
